// File: rtl/ctrl_sequencer_pkg.sv
// ctrl_sequencer_pkg: ISA constants shared by the sequencer, its decoder and the datapath.
//   - 5-bit opcode encodings (identical to the ALU command encodings)
//   - HALT_WORD: the single 9-bit word that stops the core
//   - state_t: FSM state codes kept as plain logic constants
//   - iclass_t: instruction class produced by instr_class_dec
package ctrl_sequencer_pkg;

  localparam logic [8:0] HALT_WORD = 9'h00F;

  localparam logic [4:0] OP_NOP     = 5'b00000;
  localparam logic [4:0] OP_B_LUT   = 5'b00001;
  localparam logic [4:0] OP_B       = 5'b00010;
  localparam logic [4:0] OP_BEQ     = 5'b00011;
  localparam logic [4:0] OP_INC     = 5'b00100;
  localparam logic [4:0] OP_DEC     = 5'b00101;
  localparam logic [4:0] OP_ST_IND  = 5'b00110;
  localparam logic [4:0] OP_MOV     = 5'b00111;
  localparam logic [4:0] OP_ADD     = 5'b01000;
  localparam logic [4:0] OP_SUB     = 5'b01001;
  localparam logic [4:0] OP_AND     = 5'b01010;
  localparam logic [4:0] OP_OR      = 5'b01011;
  localparam logic [4:0] OP_XOR     = 5'b01100;
  localparam logic [4:0] OP_NOT     = 5'b01101;
  localparam logic [4:0] OP_SHL     = 5'b01110;
  localparam logic [4:0] OP_SHR     = 5'b01111;
  localparam logic [4:0] OP_LD      = 5'b10000;
  localparam logic [4:0] OP_ST      = 5'b10001;
  localparam logic [4:0] OP_LD_POST = 5'b10110;
  localparam logic [4:0] OP_ST_POST = 5'b10111;
  localparam logic [4:0] OP_ADDI    = 5'b11000;
  localparam logic [4:0] OP_SUBI    = 5'b11001;
  localparam logic [4:0] OP_LD_IND  = 5'b11010;
  localparam logic [4:0] OP_LD_IDX  = 5'b11011;
  localparam logic [4:0] OP_ANDI    = 5'b11100;
  localparam logic [4:0] OP_ORI     = 5'b11101;
  localparam logic [4:0] OP_XORI    = 5'b11110;
  localparam logic [4:0] OP_SWAP    = 5'b11111;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_DECODE = 3'd2;
  localparam state_t S_EXEC   = 3'd3;
  localparam state_t S_MEM    = 3'd4;
  localparam state_t S_WB     = 3'd5;
  localparam state_t S_WB2    = 3'd6;
  localparam state_t S_HALT   = 3'd7;

  typedef enum logic [3:0] {
    IC_NOP, IC_ALU_R, IC_ALU_I, IC_LOAD, IC_STORE, IC_B, IC_BEQ, IC_BLUT, IC_SWAP
  } iclass_t;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: bus between the sequencer (master) and imem / datapath / dmem (slave).
//   control : start (in), busy, halted (out)
//   imem    : imem_addr, imem_rd_en (out), imem_rdata (in)
//   rf/alu  : rf_addr_b, rf_wr_en, rf_wr_addr, wb_sel, tmp_ld, alu_cmd, alu_src_imm, imm (out)
//   branch  : lut_idx (out), branch_eq, lut_target (in)
//   dmem    : mem_rd_en, mem_wr_en (out)
// Macro CTRL_PERF_CNT_EN adds cyc_cnt / instr_cnt (out).
interface ctrl_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic            start;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rd_en;
  logic [8:0]      imem_rdata;
  logic [3:0]      rf_addr_b;
  logic            rf_wr_en;
  logic [3:0]      rf_wr_addr;
  logic [1:0]      wb_sel;
  logic            tmp_ld;
  logic [4:0]      alu_cmd;
  logic            alu_src_imm;
  logic [7:0]      imm;
  logic            branch_eq;
  logic [3:0]      lut_idx;
  logic [PC_W-1:0] lut_target;
  logic            mem_rd_en;
  logic            mem_wr_en;
  logic            busy;
  logic            halted;
`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] instr_cnt;

  modport master (input  start, imem_rdata, branch_eq, lut_target,
                  output imem_addr, imem_rd_en, rf_addr_b, rf_wr_en, rf_wr_addr, wb_sel, tmp_ld,
                         alu_cmd, alu_src_imm, imm, lut_idx, mem_rd_en, mem_wr_en, busy, halted,
                         cyc_cnt, instr_cnt);
  modport slave  (output start, imem_rdata, branch_eq, lut_target,
                  input  imem_addr, imem_rd_en, rf_addr_b, rf_wr_en, rf_wr_addr, wb_sel, tmp_ld,
                         alu_cmd, alu_src_imm, imm, lut_idx, mem_rd_en, mem_wr_en, busy, halted,
                         cyc_cnt, instr_cnt);
`else
  modport master (input  start, imem_rdata, branch_eq, lut_target,
                  output imem_addr, imem_rd_en, rf_addr_b, rf_wr_en, rf_wr_addr, wb_sel, tmp_ld,
                         alu_cmd, alu_src_imm, imm, lut_idx, mem_rd_en, mem_wr_en, busy, halted);
  modport slave  (output start, imem_rdata, branch_eq, lut_target,
                  input  imem_addr, imem_rd_en, rf_addr_b, rf_wr_en, rf_wr_addr, wb_sel, tmp_ld,
                         alu_cmd, alu_src_imm, imm, lut_idx, mem_rd_en, mem_wr_en, busy, halted);
`endif
endinterface

// File: rtl/ctrl_sequencer_instr_class_dec.sv
// instr_class_dec: combinational instruction classifier.
//   ir      in  9  instruction word
//   iclass  out    instruction class (unlisted opcodes -> IC_NOP)
//   is_halt out 1  word equals HALT_WORD
module instr_class_dec
  import ctrl_sequencer_pkg::*;
(
  input  logic [8:0] ir,
  output iclass_t    iclass,
  output logic       is_halt
);
  always_comb begin
    is_halt = (ir == HALT_WORD);
    case (ir[8:4])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR,
      OP_INC, OP_DEC, OP_MOV:                   iclass = IC_ALU_R;
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI: iclass = IC_ALU_I;
      OP_LD, OP_LD_POST, OP_LD_IND, OP_LD_IDX:  iclass = IC_LOAD;
      OP_ST, OP_ST_POST, OP_ST_IND:             iclass = IC_STORE;
      OP_B:                                     iclass = IC_B;
      OP_BEQ:                                   iclass = IC_BEQ;
      OP_B_LUT:                                 iclass = IC_BLUT;
      OP_SWAP:                                  iclass = IC_SWAP;
      default:                                  iclass = IC_NOP;
    endcase
  end
endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle control FSM of the 8-bit core. Owns PC, IR and branch resolution,
// and sequences imem fetch, ALU/RF writeback and dmem strobes for the datapath.
//   clk, reset   system clock, asynchronous active-high reset
//   bus          ctrl_sequencer_if master modport (see interface header)
// Optional macro CTRL_PERF_CNT_EN: saturating cyc_cnt / instr_cnt performance counters.
//
// state  | meaning
// IDLE   | waiting for start after reset
// FETCH  | imem read of PC
// DECODE | latch imem word into IR, classify, detect HALT_WORD
// EXEC   | class strobes; branches resolve here
// MEM    | load data in flight
// WB     | load writeback, or SWAP first write (R0 <= Rs)
// WB2    | SWAP second write (Rs <= temp)
// HALT   | stopped, PC frozen, waiting for start
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              reset,
  ctrl_sequencer_if.master bus
);
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [8:0]      ir_q, ir_d;
  iclass_t         iclass_q, iclass_d, dec_class;
  logic            dec_halt;
  logic [PC_W-1:0] pc_inc, pc_rel;
  logic            busy_w;

  // Classify the word while it is on imem_rdata so the class is registered alongside IR.
  instr_class_dec u_dec (
    .ir      (bus.imem_rdata),
    .iclass  (dec_class),
    .is_halt (dec_halt)
  );

  assign pc_inc = pc_q + PC_W'(1);
  assign pc_rel = pc_q + {{(PC_W-4){ir_q[3]}}, ir_q[3:0]};
  assign busy_w = (state_q != S_IDLE) && (state_q != S_HALT);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    iclass_d = iclass_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d     = bus.imem_rdata;
        iclass_d = dec_class;
        state_d  = dec_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (iclass_q)
          IC_LOAD: begin state_d = S_MEM; pc_d = pc_q; end
          IC_SWAP: begin state_d = S_WB;  pc_d = pc_q; end
          IC_B:    pc_d = pc_rel;
          IC_BEQ:  if (bus.branch_eq) pc_d = pc_rel;
          IC_BLUT: pc_d = bus.lut_target;
          default: ;
        endcase
      end
      S_MEM: state_d = S_WB;
      S_WB: begin
        if (iclass_q == IC_SWAP) begin
          state_d = S_WB2;
        end else begin
          state_d = S_FETCH;
          pc_d    = pc_inc;
        end
      end
      S_WB2: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      iclass_q <= IC_NOP;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      iclass_q <= iclass_d;
    end
  end

  // Outputs depend only on registered state/IR.
  always_comb begin
    bus.imem_rd_en  = (state_q == S_FETCH);
    bus.rf_wr_en    = 1'b0;
    bus.rf_wr_addr  = 4'd0;
    bus.wb_sel      = 2'd0;
    bus.tmp_ld      = 1'b0;
    bus.alu_src_imm = 1'b0;
    bus.mem_rd_en   = 1'b0;
    bus.mem_wr_en   = 1'b0;
    bus.alu_cmd     = ir_q[8:4];
    case (state_q)
      S_EXEC: begin
        case (iclass_q)
          IC_ALU_R: bus.rf_wr_en = 1'b1;
          IC_ALU_I: begin bus.rf_wr_en = 1'b1; bus.alu_src_imm = 1'b1; end
          IC_LOAD:  bus.mem_rd_en = 1'b1;
          IC_STORE: bus.mem_wr_en = 1'b1;
          IC_SWAP:  bus.tmp_ld = 1'b1;
          default:  ;
        endcase
      end
      S_WB: begin
        bus.rf_wr_en = 1'b1;
        if (iclass_q == IC_SWAP) bus.alu_cmd = OP_MOV;
        else                     bus.wb_sel  = 2'd1;
      end
      S_WB2: begin
        bus.rf_wr_en   = 1'b1;
        bus.rf_wr_addr = ir_q[3:0];
        bus.wb_sel     = 2'd2;
      end
      default: ;
    endcase
  end

  assign bus.imem_addr = pc_q;
  assign bus.rf_addr_b = ir_q[3:0];
  assign bus.lut_idx   = ir_q[3:0];
  assign bus.imm       = {4'b0000, ir_q[3:0]};
  assign bus.busy      = busy_w;
  assign bus.halted    = (state_q == S_HALT);

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d, instr_cnt_q, instr_cnt_d;

  // The start-driven entry into FETCH happens from a non-busy state, so counting only
  // busy->FETCH transitions skips the first fetch of a run.
  always_comb begin
    cyc_cnt_d   = cyc_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (!busy_w) begin
      if (bus.start) begin
        cyc_cnt_d   = '0;
        instr_cnt_d = '0;
      end
    end else begin
      if (~&cyc_cnt_q) cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
      if ((state_d == S_FETCH) && ~&instr_cnt_q) instr_cnt_d = instr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt_q   <= '0;
      instr_cnt_q <= '0;
    end else begin
      cyc_cnt_q   <= cyc_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign bus.cyc_cnt   = cyc_cnt_q;
  assign bus.instr_cnt = instr_cnt_q;
`endif
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed programs run on ctrl_sequencer. An instruction-level model walks each
// program, expands every instruction into its expected per-cycle output records, and a negedge
// compare process checks the DUT against them; literal checks on the captured trace pin the model.
module tb_ctrl_sequencer;
  logic clk;
  logic reset;

  ctrl_sequencer_if #(.PC_W(10), .CNT_W(16)) bus ();

  ctrl_sequencer #(.PC_W(10), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] imem_addr;
    logic       imem_rd_en;
    logic [3:0] rf_addr_b;
    logic       rf_wr_en;
    logic [3:0] rf_wr_addr;
    logic [1:0] wb_sel;
    logic       tmp_ld;
    logic [4:0] alu_cmd;
    logic       alu_src_imm;
    logic [7:0] imm;
    logic [3:0] lut_idx;
    logic       mem_rd_en;
    logic       mem_wr_en;
    logic       busy;
    logic       halted;
  } obs_t;

  logic [8:0] imem [0:1023];
  obs_t       exp_q [$];
  obs_t       tr [0:63];
  int         tr_n;
  logic       mdl_run;
  logic [8:0] mdl_ir;
  int         n_chk;
  int         n_err;

  // Synchronous instruction memory: word valid the cycle after the read strobe.
  always @(posedge clk) if (bus.imem_rd_en) bus.imem_rdata <= imem[bus.imem_addr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t r;
    r.imem_addr   = bus.imem_addr;
    r.imem_rd_en  = bus.imem_rd_en;
    r.rf_addr_b   = bus.rf_addr_b;
    r.rf_wr_en    = bus.rf_wr_en;
    r.rf_wr_addr  = bus.rf_wr_addr;
    r.wb_sel      = bus.wb_sel;
    r.tmp_ld      = bus.tmp_ld;
    r.alu_cmd     = bus.alu_cmd;
    r.alu_src_imm = bus.alu_src_imm;
    r.imm         = bus.imm;
    r.lut_idx     = bus.lut_idx;
    r.mem_rd_en   = bus.mem_rd_en;
    r.mem_wr_en   = bus.mem_wr_en;
    r.busy        = bus.busy;
    r.halted      = bus.halted;
    return r;
  endfunction

  // Quiet busy cycle: fields that follow IR, no strobes.
  function automatic obs_t rec(input logic [9:0] pc, input logic [8:0] ir);
    obs_t r;
    r           = '0;
    r.imem_addr = pc;
    r.rf_addr_b = ir[3:0];
    r.lut_idx   = ir[3:0];
    r.imm       = {4'h0, ir[3:0]};
    r.alu_cmd   = ir[8:4];
    r.busy      = 1'b1;
    return r;
  endfunction

  // Execute the program in imem from PC 0 at instruction level, emitting expected cycles.
  function automatic void build();
    logic [9:0] pc;
    logic [8:0] ir;
    logic [8:0] w;
    logic [4:0] op;
    obs_t       r;
    pc = 10'd0;
    ir = mdl_ir;
    for (int n = 0; n < 32; n++) begin
      w = imem[pc];
      op = w[8:4];
      r = rec(pc, ir); r.imem_rd_en = 1'b1; exp_q.push_back(r);
      r = rec(pc, ir); exp_q.push_back(r);
      ir = w;
      if (w == 9'h00F) begin
        r = rec(pc, ir); r.busy = 1'b0; r.halted = 1'b1;
        exp_q.push_back(r);
        exp_q.push_back(r);
        break;
      end
      r = rec(pc, w);
      if (op inside {5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b01110,
                     5'b01111, 5'b00100, 5'b00101, 5'b00111}) r.rf_wr_en = 1'b1;
      if (op inside {5'b11000, 5'b11001, 5'b11100, 5'b11101, 5'b11110}) begin
        r.rf_wr_en = 1'b1; r.alu_src_imm = 1'b1;
      end
      if (op inside {5'b10000, 5'b10110, 5'b11010, 5'b11011}) r.mem_rd_en = 1'b1;
      if (op inside {5'b10001, 5'b10111, 5'b00110}) r.mem_wr_en = 1'b1;
      if (op == 5'b11111) r.tmp_ld = 1'b1;
      exp_q.push_back(r);
      if (op inside {5'b10000, 5'b10110, 5'b11010, 5'b11011}) begin
        r = rec(pc, w); exp_q.push_back(r);
        r = rec(pc, w); r.rf_wr_en = 1'b1; r.wb_sel = 2'd1; exp_q.push_back(r);
      end
      if (op == 5'b11111) begin
        r = rec(pc, w); r.rf_wr_en = 1'b1; r.alu_cmd = 5'b00111; exp_q.push_back(r);
        r = rec(pc, w); r.rf_wr_en = 1'b1; r.rf_wr_addr = w[3:0]; r.wb_sel = 2'd2;
        exp_q.push_back(r);
      end
      if (op == 5'b00010 || (op == 5'b00011 && bus.branch_eq))
        pc = pc + {{6{w[3]}}, w[3:0]};
      else if (op == 5'b00001)
        pc = bus.lut_target;
      else
        pc = pc + 10'd1;
    end
    mdl_ir = ir;
  endfunction

  always @(negedge clk) begin
    if (mdl_run && exp_q.size() > 0) begin
      obs_t a;
      obs_t e;
      a = sample();
      e = exp_q.pop_front();
      if (tr_n < 64) tr[tr_n] = a;
      chk($sformatf("cycle%0d", tr_n), 64'(a), 64'(e));
      tr_n++;
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) imem[i] = 9'h00F;
  endtask

  // Caller is at posedge+1. glitch > 0 pulses start again that many cycles in.
  task automatic run_prog(input int glitch);
    tr_n = 0;
    exp_q.delete();
    build();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    mdl_run = 1'b1;
    for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      bus.start = (glitch > 0 && c == glitch);
    end
    bus.start = 1'b0;
    mdl_run = 1'b0;
    chk("run_leftover", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    mdl_run = 1'b0;
    mdl_ir = 9'h000;
    tr_n = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.branch_eq = 1'b0;
    bus.lut_target = 10'd0;
    clear_imem();
    repeat (2) @(posedge clk); #1;
    chk("rst_busy_halted", {bus.busy, bus.halted}, 2'b00);
    chk("rst_strobes", {bus.imem_rd_en, bus.rf_wr_en, bus.mem_rd_en, bus.mem_wr_en, bus.tmp_ld}, 5'd0);
    chk("rst_alu_cmd", bus.alu_cmd, 5'd0);
    chk("rst_pc", bus.imem_addr, 10'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_start", {bus.busy, bus.halted, bus.imem_rd_en}, 3'b000);

    // ALU-R, ALU-I, LOAD, STORE, NOP, unlisted, HALT; stray start while busy
    imem[0] = 9'b01000_0101;
    imem[1] = 9'b11000_0011;
    imem[2] = 9'b10000_0010;
    imem[3] = 9'b10001_0100;
    imem[4] = 9'b00000_0000;
    imem[5] = 9'b10010_0011;
    imem[6] = 9'h00F;
    run_prog(4);
    chk("A_add_cmd", tr[2].alu_cmd, 5'b01000);
    chk("A_add_rfb", tr[2].rf_addr_b, 4'd5);
    chk("A_add_wr", {tr[2].rf_wr_en, tr[2].rf_wr_addr, tr[2].wb_sel}, {1'b1, 4'd0, 2'd0});
    chk("A_fetch_pc1", {tr[3].imem_addr, tr[3].imem_rd_en}, {10'd1, 1'b1});
    chk("A_addi", {tr[5].alu_src_imm, tr[5].imm}, {1'b1, 8'h03});
    chk("A_ld_rd", tr[8].mem_rd_en, 1'b1);
    chk("A_ld_wb", {tr[10].rf_wr_en, tr[10].wb_sel}, {1'b1, 2'd1});
    chk("A_st_wr", {tr[13].mem_wr_en, tr[14].mem_wr_en}, 2'b10);
    chk("A_halted", {tr[22].halted, tr[22].busy}, 2'b10);
    chk("A_halt_pc", tr[23].imem_addr, 10'd6);

    // BEQ taken / not taken from PC=5
    clear_imem();
    imem[0] = 9'b00010_0101;
    imem[5] = 9'b00011_1110;
    imem[3] = 9'h00F;
    imem[6] = 9'h00F;
    bus.branch_eq = 1'b1;
    run_prog(0);
    chk("B_pc5", tr[3].imem_addr, 10'd5);
    chk("B_beq_taken", tr[6].imem_addr, 10'd3);
    bus.branch_eq = 1'b0;
    run_prog(0);
    chk("B_beq_not_taken", tr[6].imem_addr, 10'd6);

    // B -1 wrap, B_LOOKUP, SWAP
    clear_imem();
    imem[0]      = 9'b00010_1111;
    imem[10'h3FF] = 9'b00001_0111;
    imem[10'h155] = 9'b11111_1001;
    imem[10'h156] = 9'h00F;
    bus.lut_target = 10'h155;
    run_prog(0);
    chk("C_wrap_pc", tr[3].imem_addr, 10'h3FF);
    chk("C_lut_idx", tr[5].lut_idx, 4'd7);
    chk("C_lut_pc", tr[6].imem_addr, 10'h155);
    chk("C_tmp_ld", tr[8].tmp_ld, 1'b1);
    chk("C_swap_wb", {tr[9].rf_wr_en, tr[9].rf_wr_addr, tr[9].wb_sel, tr[9].alu_cmd},
        {1'b1, 4'd0, 2'd0, 5'b00111});
    chk("C_swap_wb2", {tr[10].rf_wr_en, tr[10].rf_wr_addr, tr[10].wb_sel}, {1'b1, 4'd9, 2'd2});

    // three ADDs then HALT
    clear_imem();
    imem[0] = 9'b01000_0001;
    imem[1] = 9'b01000_0010;
    imem[2] = 9'b01000_0011;
    run_prog(0);
    chk("D_halt_pc", tr[12].imem_addr, 10'd3);
`ifdef CTRL_PERF_CNT_EN
    chk("D_instr_cnt", bus.instr_cnt, 16'd3);
    chk("D_cyc_cnt", bus.cyc_cnt, 16'd11);
`endif

    // reset during MEM of a LOAD
    clear_imem();
    imem[0] = 9'b10000_0010;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("E_in_mem", {bus.busy, bus.mem_rd_en, bus.rf_wr_en, bus.imem_addr}, {1'b1, 1'b0, 1'b0, 10'd0});
    reset = 1'b1;
    #1;
    chk("E_async_idle", {bus.busy, bus.halted, bus.rf_wr_en, bus.alu_cmd}, {1'b0, 1'b0, 1'b0, 5'd0});
`ifdef CTRL_PERF_CNT_EN
    chk("E_cnt_clear", {bus.cyc_cnt, bus.instr_cnt}, 32'd0);
`endif
    mdl_ir = 9'h000;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("E_after_rst%0d", i), {bus.busy, bus.rf_wr_en, bus.imem_rd_en}, 3'b000);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
